// File: rtl/usb_hid_kbd_report_decoder.sv
// HID boot-keyboard report decoder: assembles OUT payload bytes into reports, diffs each
// accepted report against the previous one and emits one press/release event per change.
module usb_hid_kbd_report_decoder #(
  parameter int NKEY     = 6,
  parameter     MOD_EVTS = "TRUE"
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_sot,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_press,
  output logic [7:0] modifiers,
  output logic       busy,
  output logic       report_drop,
  output logic       rollover_err
);

  localparam int NBYTE  = NKEY + 2;
  localparam int IW     = (NKEY > 8) ? $clog2(NKEY) : 3;
  localparam bit MOD_EN = (MOD_EVTS == "TRUE");

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_MOD_SCAN,
    S_REL_SCAN,
    S_PRS_SCAN,
    S_COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    new_q [NBYTE];
  logic [7:0]    new_d [NBYTE];
  logic [7:0]    prev_q [NKEY];
  logic [7:0]    prev_d [NKEY];
  logic [7:0]    mods_q, mods_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          evt_valid_q, evt_valid_d;
  logic [7:0]    evt_code_q, evt_code_d;
  logic          evt_press_q, evt_press_d;
  logic          busy_q, busy_d;
  logic          drop_q, drop_d;
  logic          roll_q, roll_d;

  logic          cand_evt, cand_press, scan_last, hit, roll_any, advance;
  logic [7:0]    cand_code, key, c;
  state_t        next_scan;

  // Candidate event for the current scan index; membership checks span all slots at once.
  always_comb begin
    cand_evt   = 1'b0;
    cand_press = 1'b0;
    cand_code  = 8'h00;
    scan_last  = 1'b0;
    next_scan  = S_COMMIT;
    key        = 8'h00;
    hit        = 1'b0;
    roll_any   = 1'b0;
    for (int j = 0; j < NKEY; j++) begin
      roll_any = roll_any | (new_q[j+2] == 8'h01);
    end
    case (state_q)
      S_MOD_SCAN: begin
        cand_code  = 8'hE0 | {5'b00000, idx_q[2:0]};
        cand_press = new_q[0][idx_q[2:0]];
        cand_evt   = (mods_q[idx_q[2:0]] != new_q[0][idx_q[2:0]]);
        scan_last  = (idx_q == IW'(7));
        next_scan  = S_REL_SCAN;
      end
      S_REL_SCAN: begin
        for (int j = 0; j < NKEY; j++) begin
          key = (idx_q == IW'(j)) ? prev_q[j] : key;
        end
        for (int j = 0; j < NKEY; j++) begin
          hit = hit | (new_q[j+2] == key);
        end
        cand_code = key;
        cand_evt  = (key != 8'h00) && !hit;
        scan_last = (idx_q == IW'(NKEY - 1));
        next_scan = S_PRS_SCAN;
      end
      S_PRS_SCAN: begin
        for (int j = 0; j < NKEY; j++) begin
          key = (idx_q == IW'(j)) ? new_q[j+2] : key;
        end
        // Earlier new slots with the same code count as already pressed (dedupe).
        for (int j = 0; j < NKEY; j++) begin
          hit = hit | (prev_q[j] == key) | ((IW'(j) < idx_q) && (new_q[j+2] == key));
        end
        cand_code  = key;
        cand_press = 1'b1;
        cand_evt   = (key != 8'h00) && !hit;
        scan_last  = (idx_q == IW'(NKEY - 1));
        next_scan  = S_COMMIT;
      end
      default: begin
        cand_evt = 1'b0;
      end
    endcase
  end

  // Next-state logic: byte collection, rollover check, event scan and commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    new_d       = new_q;
    prev_d      = prev_q;
    mods_d      = mods_q;
    idx_d       = idx_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_press_d = evt_press_q;
    roll_d      = 1'b0;
    advance     = 1'b0;
    c           = rx_sot ? 8'h00 : cnt_q;
    case (state_q)
      S_COLLECT: begin
        if (rx_valid && (c < 8'(NBYTE))) begin
          for (int b = 0; b < NBYTE; b++) begin
            new_d[b] = (c == 8'(b)) ? rx_data : new_q[b];
          end
          cnt_d   = c + 8'd1;
          state_d = (c == 8'(NBYTE - 1)) ? S_CHECK : S_COLLECT;
        end else begin
          cnt_d = c;
        end
      end
      S_CHECK: begin
        idx_d = {IW{1'b0}};
        if (roll_any) begin
          roll_d  = 1'b1;
          state_d = S_COLLECT;
        end else begin
          state_d = MOD_EN ? S_MOD_SCAN : S_REL_SCAN;
        end
      end
      S_MOD_SCAN, S_REL_SCAN, S_PRS_SCAN: begin
        // A pending event holds the index until the consumer takes it.
        if (evt_valid_q) begin
          evt_valid_d = !evt_ready;
          advance     = evt_ready;
        end else if (cand_evt) begin
          evt_valid_d = 1'b1;
          evt_code_d  = cand_code;
          evt_press_d = cand_press;
        end else begin
          advance = 1'b1;
        end
        if (advance && scan_last) begin
          idx_d   = {IW{1'b0}};
          state_d = next_scan;
        end else if (advance) begin
          idx_d = idx_q + IW'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      S_COMMIT: begin
        for (int j = 0; j < NKEY; j++) begin
          prev_d[j] = new_q[j+2];
        end
        mods_d  = new_q[0];
        state_d = S_COLLECT;
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
    // Bytes arriving mid-scan are dropped; the count stays full so the packet tail is ignored.
    drop_d = rx_valid && (state_q != S_COLLECT);
    busy_d = (state_d != S_COLLECT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_COLLECT;
      cnt_q       <= 8'h00;
      for (int b = 0; b < NBYTE; b++) new_q[b] <= 8'h00;
      for (int j = 0; j < NKEY; j++) prev_q[j] <= 8'h00;
      mods_q      <= 8'h00;
      idx_q       <= {IW{1'b0}};
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_press_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      roll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      new_q       <= new_d;
      prev_q      <= prev_d;
      mods_q      <= mods_d;
      idx_q       <= idx_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_press_q <= evt_press_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      roll_q      <= roll_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_code     = evt_code_q;
  assign evt_press    = evt_press_q;
  assign modifiers    = mods_q;
  assign busy         = busy_q;
  assign report_drop  = drop_q;
  assign rollover_err = roll_q;

endmodule

// File: tb/tb_usb_hid_kbd_report_decoder.sv
// Scoreboard bench for usb_hid_kbd_report_decoder: a report-level reference model queues
// expected events; a monitor pops and compares on every handshake.
module tb_usb_hid_kbd_report_decoder;

  localparam int NKEY = 6;
  localparam int NB   = NKEY + 2;

  logic       clk = 1'b0;
  logic       rstn, rx_sot, rx_valid, evt_ready;
  logic [7:0] rx_data;
  logic       evt_valid, evt_press, busy, report_drop, rollover_err;
  logic [7:0] evt_code, modifiers;

  always #8 clk = ~clk;

  usb_hid_kbd_report_decoder #(.NKEY(NKEY), .MOD_EVTS("TRUE")) dut (
    .clk(clk), .rstn(rstn), .rx_sot(rx_sot), .rx_data(rx_data), .rx_valid(rx_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
    .modifiers(modifiers), .busy(busy), .report_drop(report_drop), .rollover_err(rollover_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  int         roll_cnt = 0, drop_cnt = 0, exp_roll = 0, exp_drop = 0;
  logic [7:0] m_prev [NKEY];
  logic [7:0] m_mods;
  bit         ready_low = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready: random acceptance unless held low.
  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      evt_ready = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pulse counting, stall stability, and scoreboard pops on handshake.
  initial begin
    bit         prev_stall;
    logic [7:0] st_code;
    logic       st_press;
    logic [8:0] e;
    prev_stall = 1'b0;
    st_code    = 8'h00;
    st_press   = 1'b0;
    forever begin
      @(negedge clk);
      if (rollover_err) roll_cnt++;
      if (report_drop) drop_cnt++;
      if (rstn && prev_stall) begin
        check("stall_valid", {31'd0, evt_valid}, 32'd1);
        check("stall_code", {24'd0, evt_code}, {24'd0, st_code});
        check("stall_press", {31'd0, evt_press}, {31'd0, st_press});
      end
      if (rstn && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL evt_unexpected: got code %02h press %0b, expected no event", evt_code, evt_press);
        end else begin
          e = exp_q.pop_front();
          check("evt_code", {24'd0, evt_code}, {24'd0, e[7:0]});
          check("evt_press", {31'd0, evt_press}, {31'd0, e[8]});
        end
      end
      prev_stall = rstn && evt_valid && !evt_ready;
      st_code    = evt_code;
      st_press   = evt_press;
    end
  end

  // Reference model: compute the event list for a whole report from the diff rules.
  task automatic model_report(input logic [7:0] mods, input logic [8*NKEY-1:0] keys);
    logic [7:0] nk [NKEY];
    logic [7:0] seen[$];
    bit         roll, found;
    roll = 1'b0;
    for (int j = 0; j < NKEY; j++) begin
      nk[j] = keys[8*(NKEY-1-j) +: 8];
      if (nk[j] == 8'h01) roll = 1'b1;
    end
    if (roll) begin
      exp_roll++;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (mods[i] != m_mods[i]) exp_q.push_back({mods[i], 8'hE0 + 8'(i)});
    end
    for (int j = 0; j < NKEY; j++) begin
      found = 1'b0;
      for (int k = 0; k < NKEY; k++) if (nk[k] == m_prev[j]) found = 1'b1;
      if (m_prev[j] != 8'h00 && !found) exp_q.push_back({1'b0, m_prev[j]});
    end
    for (int k = 0; k < NKEY; k++) begin
      found = 1'b0;
      for (int j = 0; j < NKEY; j++) if (m_prev[j] == nk[k]) found = 1'b1;
      foreach (seen[s]) if (seen[s] == nk[k]) found = 1'b1;
      if (nk[k] != 8'h00 && !found) exp_q.push_back({1'b1, nk[k]});
      seen.push_back(nk[k]);
    end
    for (int j = 0; j < NKEY; j++) m_prev[j] = nk[j];
    m_mods = mods;
  endtask

  task automatic send_bytes(input logic [8*NB-1:0] pkt, input int n, input bit sot);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      rx_sot   = sot && (j == 0);
      rx_valid = 1'b1;
      rx_data  = pkt[8*(NB-1-j) +: 8];
    end
    @(posedge clk);
    #1;
    rx_sot   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || n < 4) && n < 3000);
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic wait_evt();
    int n;
    n = 0;
    while (!evt_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL evt_timeout: evt_valid=%0b after %0d cycles, expected 1", evt_valid, n);
    end
  endtask

  task automatic post_checks();
    check("modifiers", {24'd0, modifiers}, {24'd0, m_mods});
    check("rollover_cnt", roll_cnt, exp_roll);
    check("drop_cnt", drop_cnt, exp_drop);
    check("pending_evts", exp_q.size(), 32'd0);
  endtask

  task automatic do_report(input logic [7:0] mods, input logic [8*NKEY-1:0] keys);
    logic [7:0] rsv;
    rsv = 8'($urandom);
    model_report(mods, keys);
    send_bytes({mods, rsv, keys}, NB, 1'b1);
    wait_idle();
    post_checks();
  endtask

  initial begin
    logic [7:0]          mods;
    logic [8*NKEY-1:0]   keys;
    logic [8*NB-1:0]     pkt;
    int                  r;
    rstn     = 1'b0;
    rx_sot   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int j = 0; j < NKEY; j++) m_prev[j] = 8'h00;
    m_mods = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_code", {24'd0, evt_code}, 32'd0);
    check("rst_evt_press", {31'd0, evt_press}, 32'd0);
    check("rst_modifiers", {24'd0, modifiers}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {30'd0, report_drop, rollover_err}, 32'd0);
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    ready_low = 1'b0;

    // Single key press and release.
    do_report(8'h00, {8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    do_report(8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    // Modifier then key.
    do_report(8'h02, {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    do_report(8'h02, {8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00});
    do_report(8'h00, {8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00});
    // Rollover error, then a short packet that must be discarded.
    do_report(8'h00, {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01});
    send_bytes({8'h00, 8'h00, 8'h09, 8'h09, 8'h09, 8'h00, 8'h00, 8'h00}, 5, 1'b1);
    repeat (5) @(posedge clk);
    do_report(8'h00, {8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00});

    // Stalled consumer plus a byte arriving mid-scan.
    ready_low = 1'b1;
    model_report(8'h01, {8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    send_bytes({8'h01, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, NB, 1'b1);
    wait_evt();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_drop++;
    ready_low = 1'b0;
    wait_idle();
    post_checks();
    send_bytes({8'h20, 8'h00, 8'h0C, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}, NB, 1'b0);
    repeat (8) @(negedge clk);
    check("tail_busy", {31'd0, busy}, 32'd0);
    post_checks();

    // Reset in the middle of a stalled scan.
    do_report(8'h00, {8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    ready_low = 1'b1;
    send_bytes({8'h10, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, NB, 1'b1);
    wait_evt();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    for (int j = 0; j < NKEY; j++) m_prev[j] = 8'h00;
    m_mods    = 8'h00;
    ready_low = 1'b0;
    do_report(8'h00, {8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

    // Randomized reports, with occasional short packets.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        pkt = {$urandom, $urandom};
        send_bytes(pkt, $urandom_range(1, NB - 1), 1'b1);
        repeat (2) @(posedge clk);
      end else begin
        mods = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_mods;
        for (int j = 0; j < NKEY; j++) begin
          r = $urandom_range(0, 15);
          if (r < 6) keys[8*j +: 8] = 8'h00;
          else if (r == 15 && $urandom_range(0, 3) == 0) keys[8*j +: 8] = 8'h01;
          else keys[8*j +: 8] = 8'h04 + 8'(r % 8);
        end
        do_report(mods, keys);
      end
    end

    check("final_queue", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
